// File: rtl/frame_buf_multi_if.sv
// Handshake and address bus between the frame buffer controller and its
// environment (request side plus memory controller side).
interface frame_buf_multi_if #(
  parameter int ADDR_WIDTH = 29
) ();
  logic                  wr_en_in;
  logic                  rd_en_in;
  logic                  wr_rdy;
  logic                  rd_rdy;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            wr_slot;
  logic [2:0]            rd_slot;
  logic [3:0]            frame_cnt;
  logic                  full;
  logic                  empty;
  logic                  wr_frame_done;
  logic                  rd_frame_done;
  logic                  dropped;

  modport slave (
    input  wr_en_in, rd_en_in, wr_rdy, rd_rdy,
    output wr_en, rd_en, wr_addr, rd_addr, wr_slot, rd_slot, frame_cnt,
           full, empty, wr_frame_done, rd_frame_done, dropped
  );

  modport master (
    output wr_en_in, rd_en_in, wr_rdy, rd_rdy,
    input  wr_en, rd_en, wr_addr, rd_addr, wr_slot, rd_slot, frame_cnt,
           full, empty, wr_frame_done, rd_frame_done, dropped
  );
endinterface

// File: rtl/frame_buf_multi.sv
// N-slot frame buffer address controller. The writer fills one slot at a
// time and hands complete frames to the reader, so the reader never sees a
// partially written frame. Slots are used strictly in ring order.
module frame_buf_multi #(
  parameter int ADDR_WIDTH = 29,
  parameter int BASE_ADDR  = 2,
  parameter int FRAME_SIZE = 230400,
  parameter int NUM_BUFS   = 3,
  parameter int OVERWRITE  = 0,
  parameter int REPEAT     = 0
) (
  input  logic             clk,
  input  logic             reset,
  frame_buf_multi_if.slave bus
);

  localparam int                    OFF_W     = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
  localparam logic [OFF_W-1:0]      OFF_LAST  = OFF_W'(FRAME_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] FS_A      = ADDR_WIDTH'(FRAME_SIZE);
  localparam logic [2:0]            SLOT_LAST = 3'(NUM_BUFS - 1);
  localparam logic [3:0]            NB_C      = 4'(NUM_BUFS);
  localparam logic [3:0]            NB_M1     = 4'(NUM_BUFS - 1);
  localparam bit                    OW        = (OVERWRITE != 0);
  localparam bit                    RP        = (REPEAT != 0);

  typedef enum logic { W_FILL = 1'b0, W_WAIT = 1'b1 } w_state_e;
  typedef enum logic { R_IDLE = 1'b0, R_READ = 1'b1 } r_state_e;

  w_state_e              w_state_q, w_state_d;
  logic [2:0]            wr_slot_q, wr_slot_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [OFF_W-1:0]      wr_off_q, wr_off_d;

  r_state_e              r_state_q, r_state_d;
  logic [2:0]            rd_slot_q, rd_slot_d;
  logic [ADDR_WIDTH-1:0] rd_base_q, rd_base_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [OFF_W-1:0]      rd_off_q, rd_off_d;

  logic [3:0]            frame_cnt_q, frame_cnt_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  drop_q, drop_d;

  logic                  rd_busy;
  logic [3:0]            occ;
  logic                  wr_go, rd_go, wr_beat, rd_beat;
  logic                  commit, claim;

  // Ring successor of a slot index.
  function automatic logic [2:0] next_slot(input logic [2:0] slot);
    return (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
  endfunction

  // Base of the following slot, kept as a running sum instead of a multiply.
  function automatic logic [ADDR_WIDTH-1:0] next_base(input logic [2:0]            slot,
                                                      input logic [ADDR_WIDTH-1:0] base);
    return (slot == SLOT_LAST) ? BASE_A : base + FS_A;
  endfunction

  assign rd_busy = (r_state_q == R_READ);
  assign occ     = frame_cnt_q + {3'b000, rd_busy};
  assign wr_go   = (w_state_q == W_FILL) && !bus.wr_en_in && !reset;
  assign rd_go   = (r_state_q == R_READ) && !bus.rd_en_in && !reset;
  assign wr_beat = wr_go && bus.wr_rdy;
  assign rd_beat = rd_go && bus.rd_rdy;

  // Writer: advance through the frame, then commit, stall or drop at its end.
  always_comb begin
    w_state_d = w_state_q;
    wr_slot_d = wr_slot_q;
    wr_base_d = wr_base_q;
    wr_addr_d = wr_addr_q;
    wr_off_d  = wr_off_q;
    wr_done_d = 1'b0;
    drop_d    = 1'b0;
    commit    = 1'b0;
    case (w_state_q)
      W_FILL: begin
        if (wr_beat) begin
          if (wr_off_q == OFF_LAST) begin
            wr_off_d = '0;
            if ((occ < NB_M1) || !OW) begin
              commit    = 1'b1;
              wr_done_d = 1'b1;
              wr_slot_d = next_slot(wr_slot_q);
              wr_base_d = next_base(wr_slot_q, wr_base_q);
              wr_addr_d = next_base(wr_slot_q, wr_base_q);
              // Every slot is now spoken for: hold off until the reader frees one.
              if (occ >= NB_M1) w_state_d = W_WAIT;
            end else begin
              drop_d    = 1'b1;
              wr_addr_d = wr_base_q;
            end
          end else begin
            wr_off_d  = wr_off_q + OFF_W'(1);
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      W_WAIT: begin
        if (occ < NB_C) w_state_d = W_FILL;
      end
      default: w_state_d = W_FILL;
    endcase
  end

  // Reader: claim the oldest ready frame, stream it, then release or repeat.
  always_comb begin
    r_state_d = r_state_q;
    rd_slot_d = rd_slot_q;
    rd_base_d = rd_base_q;
    rd_addr_d = rd_addr_q;
    rd_off_d  = rd_off_q;
    rd_done_d = 1'b0;
    claim     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        // Frames complete in ring order, so rd_slot already names the oldest one.
        if (frame_cnt_q != 4'd0) begin
          claim     = 1'b1;
          r_state_d = R_READ;
        end
      end
      R_READ: begin
        if (rd_beat) begin
          if (rd_off_q == OFF_LAST) begin
            rd_done_d = 1'b1;
            rd_off_d  = '0;
            if (RP && (frame_cnt_q == 4'd0)) begin
              rd_addr_d = rd_base_q;
            end else begin
              rd_slot_d = next_slot(rd_slot_q);
              rd_base_d = next_base(rd_slot_q, rd_base_q);
              rd_addr_d = next_base(rd_slot_q, rd_base_q);
              r_state_d = R_IDLE;
            end
          end else begin
            rd_off_d  = rd_off_q + OFF_W'(1);
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Ready-frame count: a commit and a claim on the same edge cancel out.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (commit && !claim)      frame_cnt_d = frame_cnt_q + 4'd1;
    else if (claim && !commit) frame_cnt_d = frame_cnt_q - 4'd1;
  end

  // State registers; reset discards every frame and rewinds both pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_FILL;
      wr_slot_q   <= 3'd0;
      wr_base_q   <= BASE_A;
      wr_addr_q   <= BASE_A;
      wr_off_q    <= '0;
      r_state_q   <= R_IDLE;
      rd_slot_q   <= 3'd0;
      rd_base_q   <= BASE_A;
      rd_addr_q   <= BASE_A;
      rd_off_q    <= '0;
      frame_cnt_q <= 4'd0;
      wr_done_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      wr_slot_q   <= wr_slot_d;
      wr_base_q   <= wr_base_d;
      wr_addr_q   <= wr_addr_d;
      wr_off_q    <= wr_off_d;
      r_state_q   <= r_state_d;
      rd_slot_q   <= rd_slot_d;
      rd_base_q   <= rd_base_d;
      rd_addr_q   <= rd_addr_d;
      rd_off_q    <= rd_off_d;
      frame_cnt_q <= frame_cnt_d;
      wr_done_q   <= wr_done_d;
      rd_done_q   <= rd_done_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.wr_en         = !wr_go;
  assign bus.rd_en         = !rd_go;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.wr_slot       = wr_slot_q;
  assign bus.rd_slot       = rd_slot_q;
  assign bus.frame_cnt     = frame_cnt_q;
  assign bus.full          = (occ >= NB_M1);
  assign bus.empty         = (frame_cnt_q == 4'd0);
  assign bus.wr_frame_done = wr_done_q;
  assign bus.rd_frame_done = rd_done_q;
  assign bus.dropped       = drop_q;

endmodule

// File: tb/tb_frame_buf_multi.sv
// Bench for frame_buf_multi: three instances (stall, drop, repeat) share one
// stimulus stream; a slot-level reference model predicts each cycle's outputs
// and every accepted memory beat, and a monitor compares them independently.
module tb_frame_buf_multi;
  localparam int AW   = 29;
  localparam int BASE = 2;
  localparam int FS   = 4;
  localparam int NB   = 3;
  localparam int NI   = 3;

  typedef struct packed {
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [2:0]    wr_slot;
    logic [2:0]    rd_slot;
    logic [3:0]    frame_cnt;
    logic          full;
    logic          empty;
    logic          wfd;
    logic          rfd;
    logic          drp;
  } obs_t;

  typedef struct packed {
    obs_t [NI-1:0] c;
  } trio_t;

  typedef struct {
    int            cyc;
    int            inst;
    bit            is_rd;
    logic [AW-1:0] addr;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic s_wei, s_rei, s_wrdy, s_rrdy;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  frame_buf_multi_if #(.ADDR_WIDTH(AW)) if0 ();
  frame_buf_multi_if #(.ADDR_WIDTH(AW)) if1 ();
  frame_buf_multi_if #(.ADDR_WIDTH(AW)) if2 ();

  assign if0.wr_en_in = s_wei;  assign if0.rd_en_in = s_rei;
  assign if0.wr_rdy   = s_wrdy; assign if0.rd_rdy   = s_rrdy;
  assign if1.wr_en_in = s_wei;  assign if1.rd_en_in = s_rei;
  assign if1.wr_rdy   = s_wrdy; assign if1.rd_rdy   = s_rrdy;
  assign if2.wr_en_in = s_wei;  assign if2.rd_en_in = s_rei;
  assign if2.wr_rdy   = s_wrdy; assign if2.rd_rdy   = s_rrdy;

  frame_buf_multi #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_BUFS(NB),
                    .OVERWRITE(0), .REPEAT(0)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  frame_buf_multi #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_BUFS(NB),
                    .OVERWRITE(1), .REPEAT(0)) dut1 (.clk(clk), .reset(rst), .bus(if1));
  frame_buf_multi #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .FRAME_SIZE(FS), .NUM_BUFS(NB),
                    .OVERWRITE(0), .REPEAT(1)) dut2 (.clk(clk), .reset(rst), .bus(if2));

  obs_t act [NI];
  assign act[0] = {if0.wr_en, if0.rd_en, if0.wr_addr, if0.rd_addr, if0.wr_slot, if0.rd_slot,
                   if0.frame_cnt, if0.full, if0.empty, if0.wr_frame_done, if0.rd_frame_done, if0.dropped};
  assign act[1] = {if1.wr_en, if1.rd_en, if1.wr_addr, if1.rd_addr, if1.wr_slot, if1.rd_slot,
                   if1.frame_cnt, if1.full, if1.empty, if1.wr_frame_done, if1.rd_frame_done, if1.dropped};
  assign act[2] = {if2.wr_en, if2.rd_en, if2.wr_addr, if2.rd_addr, if2.wr_slot, if2.rd_slot,
                   if2.frame_cnt, if2.full, if2.empty, if2.wr_frame_done, if2.rd_frame_done, if2.dropped};

  trio_t stat_q[$];
  beat_t beat_q[$];

  // Reference model: per-slot state (0 free, 1 ready, 2 being read) with
  // commit stamps; the reader always takes the oldest ready slot.
  int m_st    [NI][NB];
  int m_stamp [NI][NB];
  int m_seq   [NI];
  int m_ws [NI], m_wo [NI], m_rs [NI], m_ro [NI];
  bit m_wait [NI], m_rd [NI], m_pw [NI], m_pr [NI], m_pd [NI];

  function automatic bit ow_of(int j); return (j == 1); endfunction
  function automatic bit rp_of(int j); return (j == 2); endfunction

  function automatic void model_reset(int j);
    for (int s = 0; s < NB; s++) begin
      m_st[j][s]    = 0;
      m_stamp[j][s] = 0;
    end
    m_seq[j] = 0;
    m_ws[j] = 0; m_wo[j] = 0; m_rs[j] = 0; m_ro[j] = 0;
    m_wait[j] = 0; m_rd[j] = 0; m_pw[j] = 0; m_pr[j] = 0; m_pd[j] = 0;
  endfunction

  function automatic obs_t model_step(int j, bit r, bit wei, bit rei, bit wrdy, bit rrdy);
    obs_t e;
    int   nready, occ, oldest;
    bit   wbeat, rbeat;
    nready = 0;
    for (int s = 0; s < NB; s++) if (m_st[j][s] == 1) nready++;
    occ = nready + (m_rd[j] ? 1 : 0);
    e.wr_en     = !(!r && !m_wait[j] && !wei);
    e.rd_en     = !(!r && m_rd[j] && !rei);
    e.wr_addr   = AW'(BASE + m_ws[j] * FS + m_wo[j]);
    e.rd_addr   = AW'(BASE + m_rs[j] * FS + m_ro[j]);
    e.wr_slot   = 3'(m_ws[j]);
    e.rd_slot   = 3'(m_rs[j]);
    e.frame_cnt = 4'(nready);
    e.full      = (occ >= NB - 1);
    e.empty     = (nready == 0);
    e.wfd       = m_pw[j];
    e.rfd       = m_pr[j];
    e.drp       = m_pd[j];
    if (r) begin
      model_reset(j);
      return e;
    end
    wbeat = !e.wr_en && wrdy;
    rbeat = !e.rd_en && rrdy;
    if (wbeat) beat_q.push_back('{cyc, j, 1'b0, e.wr_addr});
    if (rbeat) beat_q.push_back('{cyc, j, 1'b1, e.rd_addr});
    m_pw[j] = 0; m_pr[j] = 0; m_pd[j] = 0;
    // reader side, decided on pre-edge slot states
    if (!m_rd[j]) begin
      if (nready > 0) begin
        oldest = -1;
        for (int s = 0; s < NB; s++)
          if (m_st[j][s] == 1 && (oldest < 0 || m_stamp[j][s] < m_stamp[j][oldest])) oldest = s;
        m_st[j][oldest] = 2;
        m_rs[j] = oldest;
        m_ro[j] = 0;
        m_rd[j] = 1;
      end
    end else if (rbeat) begin
      if (m_ro[j] == FS - 1) begin
        m_pr[j] = 1;
        m_ro[j] = 0;
        if (!(rp_of(j) && nready == 0)) begin
          m_st[j][m_rs[j]] = 0;
          m_rs[j] = (m_rs[j] + 1) % NB;
          m_rd[j] = 0;
        end
      end else begin
        m_ro[j]++;
      end
    end
    // writer side, stall/drop decided on pre-edge occupancy
    if (m_wait[j]) begin
      if (occ < NB) m_wait[j] = 0;
    end else if (wbeat) begin
      if (m_wo[j] == FS - 1) begin
        m_wo[j] = 0;
        if (occ <= NB - 2 || !ow_of(j)) begin
          m_st[j][m_ws[j]]    = 1;
          m_stamp[j][m_ws[j]] = m_seq[j];
          m_seq[j]++;
          m_ws[j] = (m_ws[j] + 1) % NB;
          m_pw[j] = 1;
          if (occ > NB - 2) m_wait[j] = 1;
        end else begin
          m_pd[j] = 1;
        end
      end else begin
        m_wo[j]++;
      end
    end
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("wr_en=%b rd_en=%b wr_addr=%0d rd_addr=%0d wr_slot=%0d rd_slot=%0d frame_cnt=%0d full=%b empty=%b wfd=%b rfd=%b drop=%b",
                     o.wr_en, o.rd_en, o.wr_addr, o.rd_addr, o.wr_slot, o.rd_slot,
                     o.frame_cnt, o.full, o.empty, o.wfd, o.rfd, o.drp);
  endfunction

  function automatic void check_beat(int j, bit is_rd, logic [AW-1:0] a);
    beat_t b;
    checks++;
    if (beat_q.size() == 0) begin
      errors++;
      $display("FAIL beat inst=%0d rd=%0d cyc=%0d: actual addr=%0d, required no beat", j, is_rd, cyc, a);
      return;
    end
    b = beat_q.pop_front();
    if (b.inst != j || b.is_rd != is_rd || b.cyc != cyc || b.addr !== a) begin
      errors++;
      $display("FAIL beat: actual inst=%0d rd=%0d cyc=%0d addr=%0d, required inst=%0d rd=%0d cyc=%0d addr=%0d",
               j, is_rd, cyc, a, b.inst, b.is_rd, b.cyc, b.addr);
    end
  endfunction

  // Monitor: per-cycle status plus every accepted memory beat.
  trio_t mon_t;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mon_t = stat_q.pop_front();
      for (int j = 0; j < NI; j++) begin
        checks++;
        if (act[j] !== mon_t.c[j]) begin
          errors++;
          $display("FAIL status inst=%0d cyc=%0d actual {%s} required {%s}", j, cyc, fmt(act[j]), fmt(mon_t.c[j]));
        end
      end
      for (int j = 0; j < NI; j++) begin
        if (act[j].wr_en == 1'b0 && s_wrdy) check_beat(j, 1'b0, act[j].wr_addr);
        if (act[j].rd_en == 1'b0 && s_rrdy) check_beat(j, 1'b1, act[j].rd_addr);
      end
    end
  end

  task automatic step(bit r, bit wei, bit rei, bit wrdy, bit rrdy);
    trio_t t;
    @(posedge clk);
    #1;
    rst    = r;
    s_wei  = wei;
    s_rei  = rei;
    s_wrdy = wrdy;
    s_rrdy = rrdy;
    for (int j = 0; j < NI; j++) t.c[j] = model_step(j, r, wei, rei, wrdy, rrdy);
    stat_q.push_back(t);
  endtask

  int mode;

  initial begin
    rst = 1'b1; s_wei = 1'b0; s_rei = 1'b0; s_wrdy = 1'b1; s_rrdy = 1'b1;
    for (int j = 0; j < NI; j++) model_reset(j);
    @(posedge clk);
    // reset held with both requests active
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    // continuous single frames, full handshake
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 1);
    // write backpressure alternating
    for (int i = 0; i < 40; i++) step(0, 0, 0, (i % 2) == 0, 1);
    // mid-frame reset, then fill with the reader held off (stall / drop)
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1, 1);
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1, 1);
    // writer idle: repeat instance keeps re-reading
    step(1, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++)  step(0, 0, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 1, 1);
    for (int i = 0; i < 6; i++)  step(0, 0, 0, 1, 1);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 1, $urandom_range(0, 1) == 1);
    // randomized traffic in phases of differing reader/writer pressure
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) mode = int'($urandom_range(0, 2));
      step($urandom_range(0, 299) == 0,
           (mode == 2) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0),
           (mode == 0) ? ($urandom_range(0, 9) != 0) : (mode == 1) ? ($urandom_range(0, 9) == 0)
                                                                   : ($urandom_range(0, 1) == 1),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (stat_q.size() != 0) begin
      errors++;
      $display("FAIL status_drain: actual %0d entries left, required 0", stat_q.size());
    end
    checks++;
    if (beat_q.size() != 0) begin
      errors++;
      $display("FAIL beat_drain: actual %0d beats never seen, required 0", beat_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
